// File: rtl/axis_log_replay.sv
// Capture-and-replay buffer between the governor's log and inject AXI Streams.
// Stored flits are replayed in order through a 2-entry prefetch stage.
module axis_log_replay #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   log_TDATA,
    input  logic                    log_TVALID,
    output logic                    log_TREADY,
    input  logic [DATA_WIDTH/8-1:0] log_TKEEP,
    input  logic                    log_TDEST,
    input  logic                    log_TID,
    input  logic                    log_TLAST,
    output logic [DATA_WIDTH-1:0]   inj_TDATA,
    output logic                    inj_TVALID,
    input  logic                    inj_TREADY,
    output logic [DATA_WIDTH/8-1:0] inj_TKEEP,
    output logic                    inj_TDEST,
    output logic                    inj_TID,
    output logic                    inj_TLAST,
    input  logic                    capture,
    input  logic                    replay,
    input  logic                    clear,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    full,
    output logic                    overflow,
    output logic                    busy
);
    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int ENTRY_W = DATA_WIDTH + KEEP_W + 3;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_REPLAY
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, head_d;
    logic                  overflow_q, overflow_d;
    logic                  tready_q, tready_d;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] skid [2];

    logic               is_full;
    logic               log_hs;
    logic               wr_en;
    logic               rd_en;
    logic               pop;
    logic               push_idx;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] out_entry;

    assign is_full  = (count_q == DEPTH_CNT);
    assign log_hs   = log_TVALID && tready_q;
    assign wr_en    = (state_q == ST_CAPTURE) && log_hs && !is_full && !clear;
    assign pop      = (occ_q != 2'd0) && inj_TREADY;
    // Reads are only issued into a free skid slot, so inj_TREADY never reaches the read enable.
    assign rd_en    = (state_q == ST_REPLAY) && (rd_cnt_q != count_q) && (occ_q != 2'd2) && !clear;
    assign push_idx = head_q ^ occ_q[0];
    assign wr_entry = {log_TLAST, log_TID, log_TDEST, log_TKEEP, log_TDATA};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        occ_d      = occ_q;
        head_d     = head_q;
        overflow_d = overflow_q;
        tready_d   = 1'b1;

        if (wr_en) begin
            count_d = count_q + CNT_ONE;
            if (wr_ptr_q != '1) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end
        if ((state_q == ST_CAPTURE) && log_hs && is_full) begin
            overflow_d = 1'b1;
        end

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
        case ({rd_en, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (pop) begin
            head_d = ~head_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_CAPTURE;
                end else if (replay && (count_q != '0)) begin
                    state_d  = ST_REPLAY;
                    rd_cnt_d = '0;
                    occ_d    = 2'd0;
                    head_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (!capture) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLAY: begin
                if ((rd_cnt_d == count_q) && (occ_d == 2'd0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear empties everything and drops any pending output flit.
        if (clear) begin
            state_d    = capture ? ST_CAPTURE : ST_IDLE;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_cnt_d   = '0;
            occ_d      = 2'd0;
            head_d     = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            overflow_q <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            tready_q   <= tready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Synchronous read lands directly in the next free skid slot.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            skid[push_idx] <= mem[rd_cnt_q[DEPTH_LOG2-1:0]];
        end
    end

    assign inj_TVALID = (occ_q != 2'd0);
    assign out_entry  = inj_TVALID ? skid[head_q] : '0;
    assign {inj_TLAST, inj_TID, inj_TDEST, inj_TKEEP, inj_TDATA} = out_entry;

    assign log_TREADY = tready_q;
    assign count      = count_q;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign busy       = (state_q == ST_REPLAY);

endmodule

// File: tb/tb_axis_log_replay.sv
// Self-checking bench for axis_log_replay: random flits against a queue-based
// model of what the buffer should hold and replay.
module tb_axis_log_replay;
    localparam int DW = 32;
    localparam int DL = 3;
    localparam int D  = 1 << DL;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic          last;
        logic          id;
        logic          dest;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } flit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] log_TDATA;
    logic          log_TVALID;
    logic          log_TREADY;
    logic [KW-1:0] log_TKEEP;
    logic          log_TDEST, log_TID, log_TLAST;
    logic [DW-1:0] inj_TDATA;
    logic          inj_TVALID;
    logic          inj_TREADY;
    logic [KW-1:0] inj_TKEEP;
    logic          inj_TDEST, inj_TID, inj_TLAST;
    logic          capture, replay, clear;
    logic [DL:0]   count;
    logic          full, overflow, busy;

    int    checks = 0;
    int    fails  = 0;
    flit_t model_q[$];
    flit_t got_q[$];
    flit_t first_q[$];
    int    c_first, c_end, c_stall_err, c_gaps;
    bit    c_timeout;

    axis_log_replay #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst),
        .log_TDATA(log_TDATA), .log_TVALID(log_TVALID), .log_TREADY(log_TREADY),
        .log_TKEEP(log_TKEEP), .log_TDEST(log_TDEST), .log_TID(log_TID), .log_TLAST(log_TLAST),
        .inj_TDATA(inj_TDATA), .inj_TVALID(inj_TVALID), .inj_TREADY(inj_TREADY),
        .inj_TKEEP(inj_TKEEP), .inj_TDEST(inj_TDEST), .inj_TID(inj_TID), .inj_TLAST(inj_TLAST),
        .capture(capture), .replay(replay), .clear(clear),
        .count(count), .full(full), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t rand_flit(input logic [DW-1:0] d, input logic l);
        flit_t f;
        f.data = d;
        f.keep = KW'($urandom);
        f.id   = 1'($urandom);
        f.dest = 1'($urandom);
        f.last = l;
        return f;
    endfunction

    // Model: a flit is kept only while capturing and fewer than D are stored.
    task automatic offer(input flit_t f, input bit in_capture);
        {log_TLAST, log_TID, log_TDEST, log_TKEEP, log_TDATA} = f;
        log_TVALID = 1'b1;
        step();
        log_TVALID = 1'b0;
        if (in_capture && model_q.size() < D) model_q.push_back(f);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_q.delete();
    endtask

    task automatic capture_random(input int n);
        capture = 1'b1;
        step();
        for (int i = 0; i < n; i++) offer(rand_flit(DW'($urandom), 1'($urandom)), 1'b1);
        capture = 1'b0;
        step();
    endtask

    task automatic pulse_replay();
        replay = 1'b1;
        step();
        replay = 1'b0;
    endtask

    // Drives inj_TREADY and records what the replay stream delivers.
    task automatic collect(input int ready_pct, input int max_cycles);
        flit_t cur, prev;
        bit    prev_stall;
        got_q.delete();
        c_first = -1; c_end = -1; c_stall_err = 0; c_gaps = 0; c_timeout = 1'b0;
        prev_stall = 1'b0;
        prev = '0;
        for (int c = 0; c < max_cycles; c++) begin
            cur = {inj_TLAST, inj_TID, inj_TDEST, inj_TKEEP, inj_TDATA};
            if (prev_stall && (!inj_TVALID || cur !== prev)) c_stall_err++;
            if (!busy && !inj_TVALID) begin
                c_end = c;
                break;
            end
            if (inj_TVALID) begin
                if (c_first < 0) c_first = c;
            end else if (c_first >= 0) begin
                c_gaps++;
            end
            inj_TREADY = ($urandom_range(99) < ready_pct);
            if (inj_TVALID && inj_TREADY) got_q.push_back(cur);
            prev_stall = inj_TVALID && !inj_TREADY;
            prev = cur;
            step();
        end
        if (c_end < 0) c_timeout = 1'b1;
        inj_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (log_TREADY !== 1'b0) begin fails++; $display("[TB] FAIL reset_tready: got %b want 0", log_TREADY); end
        checks++; if (inj_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_tvalid: got %b want 0", inj_TVALID); end
        checks++; if ({inj_TLAST, inj_TID, inj_TDEST, inj_TKEEP, inj_TDATA} !== '0) begin fails++; $display("[TB] FAIL reset_inj_fields: got %h want 0", inj_TDATA); end
        checks++; if ({count, full, overflow, busy} !== '0) begin fails++; $display("[TB] FAIL reset_status: got count=%0d full=%b ovf=%b busy=%b want all 0", count, full, overflow, busy); end
        rst = 1'b0;
        step();
        checks++; if (log_TREADY !== 1'b1) begin fails++; $display("[TB] FAIL tready_after_reset: got %b want 1", log_TREADY); end
    endtask

    task automatic test_basic();
        int lasts;
        do_clear();
        capture = 1'b1;
        step();
        for (int i = 0; i < 5; i++) offer(rand_flit(DW'(2 * i + 1), (i == 4)), 1'b1);
        capture = 1'b0;
        step();
        checks++; if (count !== 4'(model_q.size())) begin fails++; $display("[TB] FAIL basic_count: got %0d want %0d", count, model_q.size()); end
        checks++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL basic_full: got %b want 0", full); end
        pulse_replay();
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_rise: got %b want 1", busy); end
        collect(100, 40);
        checks++; if (c_timeout) begin fails++; $display("[TB] FAIL basic_timeout: replay did not finish within 40 cycles"); end
        checks++; if (c_first !== 1) begin fails++; $display("[TB] FAIL basic_latency: first valid at %0d want 1 after pulse edge", c_first); end
        checks++; if (c_end !== 6) begin fails++; $display("[TB] FAIL basic_busy_fall: end at %0d want 6", c_end); end
        checks++; if (c_gaps !== 0) begin fails++; $display("[TB] FAIL basic_gaps: got %0d want 0", c_gaps); end
        checks++; if (got_q.size() !== 5) begin fails++; $display("[TB] FAIL basic_len: got %0d want 5", got_q.size()); end
        lasts = 0;
        for (int i = 0; i < got_q.size(); i++) lasts += int'(got_q[i].last);
        checks++; if (lasts !== 1) begin fails++; $display("[TB] FAIL basic_tlast_count: got %0d want 1", lasts); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_q.size()) begin fails++; $display("[TB] FAIL basic_flit%0d: missing, want %h", i, model_q[i]); end
            else if (got_q[i] !== model_q[i]) begin fails++; $display("[TB] FAIL basic_flit%0d: got %h want %h", i, got_q[i], model_q[i]); end
        end
    endtask

    task automatic test_overflow();
        do_clear();
        capture = 1'b1;
        step();
        for (int i = 0; i < D + 2; i++) begin
            offer(rand_flit(DW'($urandom), 1'($urandom)), 1'b1);
            if (i == D - 1) begin
                checks++; if (full !== 1'b1 || count !== 4'(D)) begin fails++; $display("[TB] FAIL ovf_full_at_D: got full=%b count=%0d want 1/%0d", full, count, D); end
                checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
        capture = 1'b0;
        step();
        checks++; if (count !== 4'(model_q.size())) begin fails++; $display("[TB] FAIL ovf_count: got %0d want %0d", count, model_q.size()); end
        pulse_replay();
        collect(100, 60);
        checks++; if (got_q.size() !== model_q.size() || c_timeout) begin fails++; $display("[TB] FAIL ovf_replay_len: got %0d want %0d", got_q.size(), model_q.size()); end
        for (int i = 0; i < model_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== model_q[i]) begin fails++; $display("[TB] FAIL ovf_flit%0d: got %h want %h", i, got_q[i], model_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        capture_random(8);
        pulse_replay();
        collect(50, 400);
        checks++; if (c_timeout) begin fails++; $display("[TB] FAIL bp_timeout: replay did not finish within 400 cycles"); end
        checks++; if (c_stall_err !== 0) begin fails++; $display("[TB] FAIL bp_stable: got %0d unstable stall cycles want 0", c_stall_err); end
        checks++; if (got_q.size() !== 8) begin fails++; $display("[TB] FAIL bp_len: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== model_q[i]) begin fails++; $display("[TB] FAIL bp_flit%0d: got %h want %h", i, got_q[i], model_q[i]); end
        end
    endtask

    task automatic test_clear_mid_replay();
        int  hs;
        bit  hit;
        do_clear();
        capture_random(D + 1);
        checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL clr_pre_ovf: got %b want 1", overflow); end
        pulse_replay();
        hs = 0;
        hit = 1'b0;
        inj_TREADY = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (inj_TVALID) hs++;
            if (hs == 3) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                hit = 1'b1;
                break;
            end
            step();
        end
        model_q.delete();
        checks++; if (!hit) begin fails++; $display("[TB] FAIL clr_reach_hs3: handshakes %0d want 3", hs); end
        checks++; if (inj_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL clr_tvalid: got %b want 0", inj_TVALID); end
        checks++; if (count !== '0 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL clr_status: got count=%0d ovf=%b want 0/0", count, overflow); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL clr_busy: got %b want 0", busy); end
        pulse_replay();
        for (int c = 0; c < 4; c++) begin
            checks++; if (busy !== 1'b0 || inj_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL clr_replay_ignored: got busy=%b valid=%b want 0/0", busy, inj_TVALID); end
            step();
        end
        inj_TREADY = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        capture_random(4);
        log_TDATA  = DW'($urandom);
        log_TVALID = 1'b1;
        pulse_replay();
        collect(100, 40);
        first_q = got_q;
        pulse_replay();
        collect(100, 40);
        log_TVALID = 1'b0;
        checks++; if (c_timeout || first_q.size() !== 4 || got_q.size() !== 4) begin fails++; $display("[TB] FAIL b2b_len: got %0d and %0d want 4 and 4", first_q.size(), got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size() && i < first_q.size(); i++) begin
            checks++; if (first_q[i] !== model_q[i] || got_q[i] !== model_q[i]) begin fails++; $display("[TB] FAIL b2b_flit%0d: got %h / %h want %h", i, first_q[i], got_q[i], model_q[i]); end
        end
        checks++; if (overflow !== 1'b0 || count !== 4'(model_q.size())) begin fails++; $display("[TB] FAIL b2b_discard: got ovf=%b count=%0d want 0/%0d", overflow, count, model_q.size()); end
    endtask

    task automatic test_capture_replay_same();
        do_clear();
        capture_random(3);
        capture = 1'b1;
        replay  = 1'b1;
        step();
        replay = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (busy !== 1'b0 || inj_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL same_no_replay: got busy=%b valid=%b want 0/0", busy, inj_TVALID); end
            step();
        end
        offer(rand_flit(DW'($urandom), 1'b1), 1'b1);
        checks++; if (count !== 4'(model_q.size())) begin fails++; $display("[TB] FAIL same_in_capture: got count=%0d want %0d", count, model_q.size()); end
        capture = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_replay();
        do_clear();
        capture_random(5);
        pulse_replay();
        inj_TREADY = 1'b0;
        step();
        step();
        checks++; if (inj_TVALID !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_pending: got %b want 1", inj_TVALID); end
        rst = 1'b1;
        step();
        model_q.delete();
        checks++; if ({inj_TVALID, busy, log_TREADY, full, overflow} !== '0 || count !== '0) begin fails++; $display("[TB] FAIL rstmid_outputs: got valid=%b busy=%b tready=%b count=%0d want all 0", inj_TVALID, busy, log_TREADY, count); end
        rst = 1'b0;
        step();
        pulse_replay();
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_empty: got busy=%b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1; capture = 1'b0; replay = 1'b0; clear = 1'b0; inj_TREADY = 1'b0;
        log_TVALID = 1'b0; log_TDATA = '0; log_TKEEP = '0;
        log_TDEST = 1'b0; log_TID = 1'b0; log_TLAST = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear_mid_replay();
        test_back_to_back();
        test_capture_replay_same();
        test_reset_mid_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
